// File: rtl/pss_pckt_pkg.sv
// Constants, header field positions and FSM state shared by the PSS eCPRI
// packet generator and the receive-side parser.
package pss_pckt_pkg;

  localparam int NUM_HEADER  = 5;
  localparam int NUM_RD_PCKT = 960;
  localparam int NUM_PCKT    = NUM_HEADER + NUM_RD_PCKT;
  localparam int CNT_W       = 10;
  localparam int IDX_W       = 10;
  localparam int STAT_W      = 16;
  localparam int NUM_STATS   = 5;

  localparam logic [15:0] TPID        = 16'h8100;
  localparam logic [11:0] VLAN_ID     = 12'h001;
  localparam logic [15:0] ETH_TYPE    = 16'hAEFE;
  localparam logic [7:0]  ECPRI_TYPE2 = 8'h02;
  localparam logic [7:0]  ECPRI_TYPE0 = 8'h00;

  // Field LSBs within the 64-bit header words
  localparam int MAC_LSB        = 16;
  localparam int TPID_LSB       = 16;
  localparam int VLAN_LSB       = 0;
  localparam int ETH_TYPE_LSB   = 48;
  localparam int ECPRI_TYPE_LSB = 32;
  localparam int IDX_LSB        = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    DROP    = 2'd3
  } rx_state_e;

endpackage

// File: rtl/pss_rx_stats.sv
// Saturating 16-bit event counter bank for the PSS receive parser.
// Synchronous clear takes priority over a coincident increment.
module pss_rx_stats
  import pss_pckt_pkg::*;
(
  input  logic                                clk_in,
  input  logic                                rst,
  input  logic                                clr,
  input  logic [NUM_STATS-1:0]                inc,
  output logic [NUM_STATS-1:0][STAT_W-1:0]    cnt
);

  logic [NUM_STATS-1:0][STAT_W-1:0] cnt_q, cnt_d;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NUM_STATS; i++) begin
      if (clr)
        cnt_d[i] = '0;
      else if (inc[i])
        cnt_d[i] = sat_inc(cnt_q[i]);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pss_pckt_parse.sv
// PSS eCPRI receive parser: validates the 5-word header, streams the payload
// into the sample FIFO and flags malformed/out-of-sequence frames.
// Optional build macro PSS_RX_STATS_EN adds saturating event counters.
module pss_pckt_parse
  import pss_pckt_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              din_valid,
  input  logic              din_sop,
  input  logic              din_eop,
  input  logic [DATA_W-1:0] din,
  input  logic [31:0]       local_addr_l,
  input  logic [31:0]       local_addr_h,
  input  logic              fifo_almost_full,
  output logic              fifo_wrreq,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_abort,
  output logic              pckt_done,
  output logic [IDX_W-1:0]  pckt_index,
  output logic              seq_err,
  output logic              hdr_err,
  output logic              len_err
`ifdef PSS_RX_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_good,
  output logic [STAT_W-1:0] stat_hdr_err,
  output logic [STAT_W-1:0] stat_len_err,
  output logic [STAT_W-1:0] stat_drop,
  output logic [STAT_W-1:0] stat_seq_err
`endif
);

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  exp_idx_q, exp_idx_d;
  logic [IDX_W-1:0]  pckt_index_q, pckt_index_d;
  logic              first_q, first_d;
  logic              wr_d, abort_d, done_d, seq_d, hdr_d, len_d;
  logic              fifo_abort_q, pckt_done_q, seq_err_q, hdr_err_q, len_err_q;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [47:0]       local_mac;
  logic              w0_ok, hdr_word_ok, start;
  logic              unused_addr_h;

  assign local_mac     = {local_addr_h[15:0], local_addr_l};
  assign unused_addr_h = |local_addr_h[31:16];
  assign w0_ok         = (din[MAC_LSB +: 48] == local_mac);

  function automatic logic [CNT_W-1:0] cnt_inc_sat(input logic [CNT_W-1:0] c);
    return (c >= CNT_W'(NUM_PCKT)) ? CNT_W'(NUM_PCKT) : c + 1'b1;
  endfunction

  always_comb begin
    hdr_word_ok = 1'b1;
    case (cnt_q)
      CNT_W'(1): hdr_word_ok = (din[TPID_LSB +: 16] == TPID) &&
                               (din[VLAN_LSB +: 12] == VLAN_ID);
      CNT_W'(2): hdr_word_ok = (din[ETH_TYPE_LSB +: 16] == ETH_TYPE) &&
                               (din[ECPRI_TYPE_LSB +: 8] == ECPRI_TYPE2);
      CNT_W'(3): hdr_word_ok = (din[ECPRI_TYPE_LSB +: 8] == ECPRI_TYPE0);
      default:   hdr_word_ok = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    exp_idx_d    = exp_idx_q;
    pckt_index_d = pckt_index_q;
    first_d      = first_q;
    wr_d         = 1'b0;
    abort_d      = 1'b0;
    done_d       = 1'b0;
    seq_d        = 1'b0;
    hdr_d        = 1'b0;
    len_d        = 1'b0;
    start        = 1'b0;

    if (din_valid) begin
      if (din_sop) begin
        // A sop outside IDLE truncates the frame in flight
        start = 1'b1;
        if (state_q != IDLE) begin
          len_d   = 1'b1;
          abort_d = (state_q == PAYLOAD);
        end
      end else begin
        case (state_q)
          HDR: begin
            if (din_eop) begin
              len_d   = 1'b1;
              state_d = IDLE;
            end else if (!hdr_word_ok) begin
              hdr_d   = 1'b1;
              state_d = DROP;
            end else begin
              cnt_d = cnt_inc_sat(cnt_q);
              if (cnt_q == CNT_W'(3))
                idx_d = din[IDX_LSB +: IDX_W];
              if (cnt_q == CNT_W'(NUM_HEADER - 1))
                state_d = PAYLOAD;
            end
          end
          PAYLOAD: begin
            wr_d  = 1'b1;
            cnt_d = cnt_inc_sat(cnt_q);
            if (cnt_q == CNT_W'(NUM_PCKT - 1)) begin
              if (din_eop) begin
                done_d       = 1'b1;
                pckt_index_d = idx_q;
                seq_d        = !first_q && (idx_q != exp_idx_q);
                exp_idx_d    = idx_q + 1'b1;
                first_d      = 1'b0;
                state_d      = IDLE;
              end else begin
                len_d   = 1'b1;
                abort_d = 1'b1;
                state_d = DROP;
              end
            end else if (din_eop) begin
              len_d   = 1'b1;
              abort_d = 1'b1;
              state_d = IDLE;
            end
          end
          DROP:    if (din_eop) state_d = IDLE;
          default: state_d = state_q;
        endcase
      end

      if (start) begin
        cnt_d = CNT_W'(1);
        if (fifo_almost_full)
          state_d = din_eop ? IDLE : DROP;
        else if (din_eop) begin
          len_d   = 1'b1;
          state_d = IDLE;
        end else if (!w0_ok) begin
          hdr_d   = 1'b1;
          state_d = DROP;
        end else
          state_d = HDR;
      end
    end

    if (state_d == IDLE)
      cnt_d = '0;
  end

  // Output stage: everything below is registered once after the input word
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      exp_idx_q    <= '0;
      pckt_index_q <= '0;
      first_q      <= 1'b1;
      vld_p1       <= 1'b0;
      fifo_abort_q <= 1'b0;
      pckt_done_q  <= 1'b0;
      seq_err_q    <= 1'b0;
      hdr_err_q    <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      exp_idx_q    <= exp_idx_d;
      pckt_index_q <= pckt_index_d;
      first_q      <= first_d;
      vld_p1       <= wr_d;
      fifo_abort_q <= abort_d;
      pckt_done_q  <= done_d;
      seq_err_q    <= seq_d;
      hdr_err_q    <= hdr_d;
      len_err_q    <= len_d;
    end
  end

  always_ff @(posedge clk_in) begin
    idx_q   <= idx_d;
    data_p1 <= din;
  end

  assign fifo_wrreq = vld_p1;
  assign fifo_data  = data_p1 & {DATA_W{vld_p1}};
  assign fifo_abort = fifo_abort_q;
  assign pckt_done  = pckt_done_q;
  assign pckt_index = pckt_index_q;
  assign seq_err    = seq_err_q;
  assign hdr_err    = hdr_err_q;
  assign len_err    = len_err_q;

`ifdef PSS_RX_STATS_EN
  logic                            drop_q;
  logic [NUM_STATS-1:0][STAT_W-1:0] stat_cnt;

  always_ff @(posedge clk_in) begin
    if (rst)
      drop_q <= 1'b0;
    else
      drop_q <= din_valid && din_sop && fifo_almost_full;
  end

  pss_rx_stats u_stats (
    .clk_in (clk_in),
    .rst    (rst),
    .clr    (stat_clr),
    .inc    ({seq_err_q, drop_q, len_err_q, hdr_err_q, pckt_done_q}),
    .cnt    (stat_cnt)
  );

  assign stat_good    = stat_cnt[0];
  assign stat_hdr_err = stat_cnt[1];
  assign stat_len_err = stat_cnt[2];
  assign stat_drop    = stat_cnt[3];
  assign stat_seq_err = stat_cnt[4];
`endif

endmodule

// File: tb/tb_pss_pckt_parse.sv
// Self-checking bench for pss_pckt_parse: table of frame scenarios plus
// hand-written reset and truncation sequences, payload checked by scoreboard.
module tb_pss_pckt_parse;
  import pss_pckt_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst = 1'b1;
  logic        din_valid = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic [63:0] din = '0;
  logic [31:0] local_addr_l = 32'h4567_89AB;
  logic [31:0] local_addr_h = 32'h0000_0123;
  logic        fifo_almost_full = 1'b0;
  logic        fifo_wrreq, fifo_abort, pckt_done, seq_err, hdr_err, len_err;
  logic [63:0] fifo_data;
  logic [9:0]  pckt_index;
`ifdef PSS_RX_STATS_EN
  logic        stat_clr = 1'b0;
  logic [15:0] stat_good, stat_hdr_err, stat_len_err, stat_drop, stat_seq_err;
`endif

  localparam logic [47:0] MAC = 48'h0123_4567_89AB;

  pss_pckt_parse dut (
    .clk_in(clk_in), .rst(rst), .din_valid(din_valid), .din_sop(din_sop),
    .din_eop(din_eop), .din(din), .local_addr_l(local_addr_l),
    .local_addr_h(local_addr_h), .fifo_almost_full(fifo_almost_full),
    .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .fifo_abort(fifo_abort),
    .pckt_done(pckt_done), .pckt_index(pckt_index), .seq_err(seq_err),
    .hdr_err(hdr_err), .len_err(len_err)
`ifdef PSS_RX_STATS_EN
    , .stat_clr(stat_clr), .stat_good(stat_good), .stat_hdr_err(stat_hdr_err),
    .stat_len_err(stat_len_err), .stat_drop(stat_drop), .stat_seq_err(stat_seq_err)
`endif
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  int n_wr, n_done, n_hdr, n_len, n_abort, n_seq;
  int unsigned abort_cyc, done_cyc, sop_cyc, last_push_cyc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic clr_counts();
    n_wr = 0; n_done = 0; n_hdr = 0; n_len = 0; n_abort = 0; n_seq = 0;
    abort_cyc = 0; done_cyc = 0;
  endtask

  always @(negedge clk_in) begin
    if (fifo_wrreq) begin
      n_wr++;
      if (exp_q.size() == 0)
        chk("unexpected_wrreq", 64'd1, 64'd0);
      else
        chk("fifo_data", fifo_data, exp_q.pop_front());
    end
    if (fifo_abort) begin n_abort++; abort_cyc = cyc; end
    if (pckt_done)  begin n_done++;  done_cyc = cyc;  end
    if (hdr_err) n_hdr++;
    if (len_err) n_len++;
    if (seq_err) n_seq++;
  end

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 rst = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic [9:0] idx, input bit bad_eth,
                            input bit bad_mac, input bit push, input bit gaps,
                            input bit with_eop);
    logic [63:0] w;
    for (int k = 1; k <= n; k++) begin
      if (gaps && (k % 7 == 0)) begin
        din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
        @(posedge clk_in); #1;
      end
      case (k)
        1: w = {bad_mac ? (MAC ^ 48'h1) : MAC, 16'h0000};
        2: w = {32'h0, 16'h8100, 4'h0, 12'h001};
        3: w = {bad_eth ? 16'h0800 : 16'hAEFE, 8'h00, 8'h02, 32'h0};
        4: w = {24'h0, 8'h00, 22'h0, idx};
        default: w = {$urandom(), $urandom()};
      endcase
      din_valid = 1'b1;
      din_sop   = (k == 1);
      din_eop   = with_eop && (k == n);
      din       = w;
      if (k == 1) sop_cyc = cyc;
      if (push && k > NUM_HEADER && k <= NUM_PCKT) begin
        exp_q.push_back(w);
        last_push_cyc = cyc;
      end
      @(posedge clk_in); #1;
    end
    din_valid = 1'b0; din_sop = 1'b0; din_eop = 1'b0;
  endtask

  typedef struct {
    bit         do_rst;
    int         n;
    logic [9:0] idx;
    bit         bad_eth, bad_mac, af, gaps;
    int         e_wr;
    bit         e_done, e_hdr, e_len, e_abort, e_seq;
    logic [9:0] e_idx;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    //          rst  n    idx  eth mac af gap wr  dn hd ln ab sq e_idx
    tbl[0]  = '{0, 965,   5,   0, 0, 0, 0, 960, 1, 0, 0, 0, 0, 10'd5};
    tbl[1]  = '{1, 965, 1023,  0, 0, 0, 0, 960, 1, 0, 0, 0, 0, 10'd1023};
    tbl[2]  = '{0, 965,   0,   0, 0, 0, 0, 960, 1, 0, 0, 0, 0, 10'd0};
    tbl[3]  = '{0, 965,   2,   0, 0, 0, 0, 960, 1, 0, 0, 0, 1, 10'd2};
    tbl[4]  = '{0, 965,   7,   1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 10'd2};
    tbl[5]  = '{0, 965,   3,   0, 0, 0, 0, 960, 1, 0, 0, 0, 0, 10'd3};
    tbl[6]  = '{0, 500,   4,   0, 0, 0, 0, 495, 0, 0, 1, 1, 0, 10'd3};
    tbl[7]  = '{0, 970,   4,   0, 0, 0, 0, 960, 0, 0, 1, 1, 0, 10'd3};
    tbl[8]  = '{0, 965,   4,   0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 10'd3};
    tbl[9]  = '{0, 965,   4,   0, 0, 0, 1, 960, 1, 0, 0, 0, 0, 10'd4};
    tbl[10] = '{0,   3,   5,   0, 0, 0, 0,   0, 0, 0, 1, 0, 0, 10'd4};
    tbl[11] = '{0, 965,   5,   0, 1, 0, 0,   0, 0, 1, 0, 0, 0, 10'd4};

    apply_reset();
    chk("rst_wrreq", fifo_wrreq, 0);
    chk("rst_abort", fifo_abort, 0);
    chk("rst_done", pckt_done, 0);
    chk("rst_index", pckt_index, 0);
    chk("rst_errs", {seq_err, hdr_err, len_err}, 0);

    for (int r = 0; r < 12; r++) begin
      if (tbl[r].do_rst) apply_reset();
      clr_counts();
      fifo_almost_full = tbl[r].af;
      send_frame(tbl[r].n, tbl[r].idx, tbl[r].bad_eth, tbl[r].bad_mac,
                 !(tbl[r].bad_eth || tbl[r].bad_mac || tbl[r].af), tbl[r].gaps, 1'b1);
      fifo_almost_full = 1'b0;
      repeat (4) @(posedge clk_in); #1;
      chk($sformatf("row%0d_writes", r), n_wr, tbl[r].e_wr);
      chk($sformatf("row%0d_done", r), n_done, tbl[r].e_done);
      chk($sformatf("row%0d_hdr_err", r), n_hdr, tbl[r].e_hdr);
      chk($sformatf("row%0d_len_err", r), n_len, tbl[r].e_len);
      chk($sformatf("row%0d_abort", r), n_abort, tbl[r].e_abort);
      chk($sformatf("row%0d_seq_err", r), n_seq, tbl[r].e_seq);
      chk($sformatf("row%0d_index", r), pckt_index, tbl[r].e_idx);
      chk($sformatf("row%0d_sb_left", r), exp_q.size(), 0);
      if (tbl[r].e_abort)
        chk($sformatf("row%0d_abort_cyc", r), abort_cyc, last_push_cyc + 1);
      if (tbl[r].e_done)
        chk($sformatf("row%0d_done_cyc", r), done_cyc, last_push_cyc + 1);
    end

`ifdef PSS_RX_STATS_EN
    chk("stat_good", stat_good, 5);
    chk("stat_hdr_err", stat_hdr_err, 2);
    chk("stat_len_err", stat_len_err, 3);
    chk("stat_drop", stat_drop, 1);
    chk("stat_seq_err", stat_seq_err, 1);
    stat_clr = 1'b1;
    @(posedge clk_in); #1;
    stat_clr = 1'b0;
    chk("stat_clr_good", stat_good, 0);
    chk("stat_clr_drop", stat_drop, 0);
`endif

    // Reset in the middle of the payload, then a fresh good frame
    clr_counts();
    send_frame(200, 10'd50, 0, 0, 1, 0, 1'b0);
    @(negedge clk_in);
    rst = 1'b1;
    @(posedge clk_in); #1;
    chk("midrst_wrreq", fifo_wrreq, 0);
    chk("midrst_index", pckt_index, 0);
    chk("midrst_flags", {fifo_abort, pckt_done, seq_err, hdr_err, len_err}, 0);
    chk("midrst_writes", n_wr, 195);
    chk("midrst_sb_left", exp_q.size(), 0);
    rst = 1'b0;
    clr_counts();
    send_frame(965, 10'd77, 0, 0, 1, 0, 1'b1);
    repeat (4) @(posedge clk_in); #1;
    chk("postrst_done", n_done, 1);
    chk("postrst_seq", n_seq, 0);
    chk("postrst_index", pckt_index, 77);
    chk("postrst_writes", n_wr, 960);

    // sop arriving mid-payload truncates the frame; the new frame still parses
    clr_counts();
    send_frame(300, 10'd90, 0, 0, 1, 0, 1'b0);
    send_frame(965, 10'd78, 0, 0, 1, 0, 1'b1);
    repeat (4) @(posedge clk_in); #1;
    chk("trunc_len", n_len, 1);
    chk("trunc_abort", n_abort, 1);
    chk("trunc_abort_cyc", abort_cyc, sop_cyc + 1);
    chk("trunc_writes", n_wr, 295 + 960);
    chk("trunc_done", n_done, 1);
    chk("trunc_done_cyc", done_cyc, last_push_cyc + 1);
    chk("trunc_seq", n_seq, 0);
    chk("trunc_index", pckt_index, 78);
    chk("trunc_sb_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
